// File: rtl/logic_reduce_unit_pkg.sv
// Shared op encoding and bitwise helpers for the logic reduce unit.
// Helpers work on MAX_W-bit words; callers truncate to their own WIDTH.
package logic_unit_pkg;

  localparam int MAX_W = 64;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  function automatic logic is_inv(input logic [2:0] op);
    return (op == OP_NOR) || (op == OP_NAND) || (op == OP_XNOR);
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

  function automatic logic [2:0] base_op(input logic [2:0] op);
    case (op)
      OP_NOR:  return OP_OR;
      OP_NAND: return OP_AND;
      OP_XNOR: return OP_XOR;
      default: return op;
    endcase
  endfunction

  // AND folds start from all ones within the active width, everything else from zero.
  function automatic logic [MAX_W-1:0] identity(input logic [2:0] op, input int width);
    if (base_op(op) == OP_AND) return {MAX_W{1'b1}} >> (MAX_W - width);
    return '0;
  endfunction

  function automatic logic [MAX_W-1:0] apply(input logic [2:0] base,
                                             input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b);
    case (base)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry output buffer; head drives the consumer, tail absorbs one extra result.
// Ready to the producer depends only on registered occupancy.
module skid_buffer_2 #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign wr_ready = (count != 2'd2);
  assign rd_valid = (count != 2'd0);
  assign rd_data  = head;
  assign pop      = rd_valid && rd_ready;
  assign push     = wr_valid && (wr_ready || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= wr_data;
          else               tail <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= wr_data;
          end else begin
            head <= tail;
            tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Reduces N_IN operand words with a selectable bitwise op, optionally accumulating a packet.
// WIDTH is limited to logic_unit_pkg::MAX_W bits.
module logic_reduce_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [2:0]            in_op,
  input  logic                  in_acc,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err
);

  logic             pkt_open;
  logic [2:0]       op_lat;
  logic [WIDTH-1:0] acc;

  logic [2:0]       op_eff;
  logic [2:0]       base;
  logic [WIDTH-1:0] stage [N_IN+1];
  logic [WIDTH-1:0] combined;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             push;
  logic [WIDTH:0]   rd_word;

  // Once a packet is open its first beat's op governs every later beat.
  assign op_eff = pkt_open ? op_lat : in_op;
  assign base   = base_op(op_eff);

  assign stage[0] = WIDTH'(identity(op_eff, WIDTH));
  for (genvar k = 0; k < N_IN; k++) begin : g_tree
    assign stage[k+1] = WIDTH'(apply(base, MAX_W'(stage[k]), MAX_W'(in_data[k*WIDTH +: WIDTH])));
  end

  assign combined = pkt_open ? WIDTH'(apply(base, MAX_W'(acc), MAX_W'(stage[N_IN])))
                             : stage[N_IN];
  assign result   = !is_legal(op_eff) ? '0 : (is_inv(op_eff) ? ~combined : combined);

  assign accept = in_valid && in_ready;
  assign push   = accept && (!in_acc || in_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_open <= 1'b0;
      op_lat   <= '0;
      acc      <= '0;
    end else if (accept) begin
      if (in_acc && !in_last) begin
        pkt_open <= 1'b1;
        acc      <= combined;
        if (!pkt_open) op_lat <= in_op;
      end else begin
        pkt_open <= 1'b0;
        acc      <= '0;
      end
    end
  end

  skid_buffer_2 #(.DW(WIDTH + 1)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (push),
    .wr_data  ({!is_legal(op_eff), result}),
    .wr_ready (in_ready),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_word)
  );

  assign out_data = rd_word[WIDTH-1:0];
  assign out_err  = rd_word[WIDTH];

endmodule
